// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns PCF, issues in-order requests to a
// variable-latency instruction memory, buffers responses and drives IF/ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        StallD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  localparam int          AW  = $clog2(FIFO_DEPTH);
  localparam int          CW  = AW + 1;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic [31:0]   pcf;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;
  logic [CW-1:0] fifo_count;
  logic [AW-1:0] fifo_rd, fifo_wr;
  logic [AW-1:0] tag_rd, tag_wr;
  logic [31:0]   fifo_instr [FIFO_DEPTH];
  logic [31:0]   fifo_pc    [FIFO_DEPTH];
  logic [31:0]   tag_q      [FIFO_DEPTH];

  logic          fifo_empty;
  logic          pop;
  logic          push;
  logic          grant;
  logic          resp_keep;
  logic          load_en;
  logic          bypass;
  logic          credit_ok;
  logic [CW:0]   credit_used;
  logic [31:0]   resp_tag;

  always_comb begin
    fifo_empty  = (fifo_count == '0);
    pop         = !fifo_empty && !StallD && !PCSrcE;
    credit_used = {1'b0, outstanding} + {1'b0, fifo_count} - {{CW{1'b0}}, pop};
    credit_ok   = (credit_used < (CW+1)'(FIFO_DEPTH));
    imem_req    = !reset && !PCSrcE && credit_ok;
    grant       = imem_req && imem_gnt;
    resp_keep   = imem_rvalid && (discard == '0);
    load_en     = !PCSrcE && !StallD;
    // A kept response landing on an empty buffer goes straight into IF/ID.
    bypass      = load_en && fifo_empty && resp_keep;
    push        = resp_keep && !PCSrcE && !bypass;
    resp_tag    = tag_q[tag_rd];
  end

  assign imem_addr = pcf;

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf         <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      fifo_rd     <= '0;
      fifo_wr     <= '0;
      tag_rd      <= '0;
      tag_wr      <= '0;
      InstrD      <= NOP;
      PCD         <= '0;
      PCPlus4D    <= '0;
      ValidD      <= 1'b0;
    end else begin
      if (PCSrcE) begin
        pcf <= PCTargetE & 32'hFFFF_FFFC;
      end else if (grant) begin
        pcf <= pcf + 32'd4;
      end

      if (grant) begin
        tag_q[tag_wr] <= pcf;
        tag_wr        <= tag_wr + AW'(1);
      end
      if (imem_rvalid) begin
        tag_rd <= tag_rd + AW'(1);
      end
      outstanding <= outstanding + CW'(grant) - CW'(imem_rvalid);

      // Everything still in flight at a redirect belongs to the old path.
      if (PCSrcE) begin
        discard <= outstanding - CW'(imem_rvalid);
      end else if (imem_rvalid && (discard != '0)) begin
        discard <= discard - CW'(1);
      end

      if (PCSrcE) begin
        fifo_count <= '0;
        fifo_rd    <= '0;
        fifo_wr    <= '0;
      end else begin
        if (push) begin
          fifo_instr[fifo_wr] <= imem_rdata;
          fifo_pc[fifo_wr]    <= resp_tag;
          fifo_wr             <= fifo_wr + AW'(1);
        end
        if (pop) begin
          fifo_rd <= fifo_rd + AW'(1);
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end

      if (PCSrcE) begin
        ValidD <= 1'b0;
        InstrD <= NOP;
      end else if (!StallD) begin
        if (!fifo_empty) begin
          InstrD   <= fifo_instr[fifo_rd];
          PCD      <= fifo_pc[fifo_rd];
          PCPlus4D <= fifo_pc[fifo_rd] + 32'd4;
          ValidD   <= 1'b1;
        end else if (bypass) begin
          InstrD   <= imem_rdata;
          PCD      <= resp_tag;
          PCPlus4D <= resp_tag + 32'd4;
          ValidD   <= 1'b1;
        end else begin
          ValidD <= 1'b0;
          InstrD <= NOP;
        end
      end
    end
  end

  a_rvalid_outstanding : assert property (@(posedge clk) disable iff (reset)
    imem_rvalid |-> (outstanding != '0));

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    (push && !pop) |-> (fifo_count < CW'(FIFO_DEPTH)));

endmodule
